// File: rtl/div_seq_datapath_if.sv
// Start/done handshake bundle for the sequential divider.
// The master drives the operands and start; the slave returns status and results.
interface div_seq_datapath_if #(
   parameter int W = 16
);
   logic         start;
   logic [W-1:0] dividend;
   logic [W-1:0] divisor;
   logic         busy;
   logic         done;
   logic [W-1:0] quotient;
   logic [W-1:0] remainder;
   logic         div_by_zero;

   modport master (
      output start, dividend, divisor,
      input  busy, done, quotient, remainder, div_by_zero
   );

   modport slave (
      input  start, dividend, divisor,
      output busy, done, quotient, remainder, div_by_zero
   );
endinterface

// File: rtl/div_seq_datapath.sv
// Unsigned divider by repeated subtraction: one compare/subtract decision per cycle,
// with registered results held until the next accepted division completes.
module div_seq_datapath #(
   parameter int W = 16
) (
   input  logic               clk,
   input  logic               rst_n,
   div_seq_datapath_if.slave  bus
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      SUB  = 2'd1,
      DONE = 2'd2
   } state_t;

   state_t       state_reg;
   logic [W-1:0] r_reg;
   logic [W-1:0] d_reg;
   logic [W-1:0] q_reg;
   logic [W-1:0] quot_reg;
   logic [W-1:0] rem_reg;
   logic         done_reg;
   logic         dbz_reg;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_reg <= IDLE;
         r_reg     <= '0;
         d_reg     <= '0;
         q_reg     <= '0;
         quot_reg  <= '0;
         rem_reg   <= '0;
         done_reg  <= 1'b0;
         dbz_reg   <= 1'b0;
      end else begin
         done_reg <= 1'b0;
         case (state_reg)
            IDLE: begin
               if (bus.start) begin
                  r_reg     <= bus.dividend;
                  d_reg     <= bus.divisor;
                  q_reg     <= '0;
                  state_reg <= SUB;
               end
            end
            SUB: begin
               if (d_reg == '0) begin
                  // Zero divisor: report the dividend untouched as the remainder.
                  quot_reg  <= '0;
                  rem_reg   <= r_reg;
                  dbz_reg   <= 1'b1;
                  done_reg  <= 1'b1;
                  state_reg <= DONE;
               end else if (r_reg >= d_reg) begin
                  r_reg <= r_reg - d_reg;
                  q_reg <= q_reg + W'(1);
               end else begin
                  quot_reg  <= q_reg;
                  rem_reg   <= r_reg;
                  dbz_reg   <= 1'b0;
                  done_reg  <= 1'b1;
                  state_reg <= DONE;
               end
            end
            DONE: begin
               state_reg <= IDLE;
            end
            default: begin
               state_reg <= IDLE;
            end
         endcase
      end
   end

   assign bus.busy        = (state_reg != IDLE);
   assign bus.done        = done_reg;
   assign bus.quotient    = quot_reg;
   assign bus.remainder   = rem_reg;
   assign bus.div_by_zero = dbz_reg;

endmodule

// File: tb/tb_div_seq_datapath.sv
// Self-checking bench for div_seq_datapath: directed cases plus random divisions
// compared against plain integer division and the expected done latency.
module tb_div_seq_datapath;

   localparam int W = 16;

   logic clk;
   logic rst_n;
   int   checks;
   int   errors;

   logic [W-1:0] last_q;
   logic [W-1:0] last_r;
   logic         last_z;

   div_seq_datapath_if #(.W(W)) bus ();

   div_seq_datapath #(.W(W)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   // Launches one division and follows it to the end of its done pulse.
   // If inj > 0, a second start with operands 7/7 is pulsed inj edges after the accept.
   task automatic run_div(input logic [W-1:0] a, input logic [W-1:0] b,
                          input int inj, input string tag);
      logic [W-1:0] exp_q;
      logic [W-1:0] exp_r;
      logic         exp_z;
      int           exp_lat;
      int           n;
      bit           seen;
      bit           busy_ok;
      bit           stable_ok;

      if (b == '0) begin
         exp_q   = '0;
         exp_r   = a;
         exp_z   = 1'b1;
         exp_lat = 1;
      end else begin
         exp_q   = a / b;
         exp_r   = a % b;
         exp_z   = 1'b0;
         exp_lat = int'(exp_q) + 1;
      end

      @(negedge clk);
      bus.start    = 1'b1;
      bus.dividend = a;
      bus.divisor  = b;
      @(posedge clk);
      #1;
      bus.start    = 1'b0;
      bus.dividend = W'($urandom);
      bus.divisor  = W'($urandom);

      n         = 0;
      seen      = 1'b0;
      busy_ok   = 1'b1;
      stable_ok = 1'b1;
      while (!seen && n < exp_lat + 8) begin
         if (bus.busy !== 1'b1) busy_ok = 1'b0;
         if (bus.quotient !== last_q || bus.remainder !== last_r ||
             bus.div_by_zero !== last_z) stable_ok = 1'b0;
         @(posedge clk);
         #1;
         n++;
         if (inj > 0 && n == inj) begin
            bus.start    = 1'b1;
            bus.dividend = W'(7);
            bus.divisor  = W'(7);
         end else if (inj > 0 && n == inj + 1) begin
            bus.start = 1'b0;
         end
         if (bus.done === 1'b1) seen = 1'b1;
      end

      check({tag, " latency"}, n, exp_lat);
      check({tag, " busy_in_sub"}, busy_ok, 1);
      check({tag, " result_hold"}, stable_ok, 1);
      check({tag, " quotient"}, bus.quotient, exp_q);
      check({tag, " remainder"}, bus.remainder, exp_r);
      check({tag, " dbz"}, bus.div_by_zero, exp_z);
      check({tag, " busy_in_done"}, bus.busy, 1);
      @(posedge clk);
      #1;
      check({tag, " done_pulse_end"}, bus.done, 0);
      check({tag, " busy_idle"}, bus.busy, 0);
      $display("div %s: %0d / %0d -> q=%0d r=%0d dbz=%0d latency=%0d",
               tag, a, b, bus.quotient, bus.remainder, bus.div_by_zero, n);
      last_q = exp_q;
      last_r = exp_r;
      last_z = exp_z;
   endtask

   initial begin
      logic [W-1:0] ra;
      logic [W-1:0] rb;

      checks       = 0;
      errors       = 0;
      last_q       = '0;
      last_r       = '0;
      last_z       = 1'b0;
      bus.start    = 1'b0;
      bus.dividend = '0;
      bus.divisor  = '0;
      rst_n        = 1'b0;

      #12;
      check("reset busy", bus.busy, 0);
      check("reset done", bus.done, 0);
      check("reset quotient", bus.quotient, 0);
      check("reset remainder", bus.remainder, 0);
      check("reset dbz", bus.div_by_zero, 0);
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk);

      run_div(16'd100, 16'd7, 0, "100/7");
      run_div(16'd5, 16'd9, 0, "5/9");
      run_div(16'd0, 16'd3, 0, "0/3");
      run_div(16'd1234, 16'd0, 0, "1234/0");
      run_div(16'd9, 16'd3, 0, "9/3");
      run_div(16'd65535, 16'd1, 0, "65535/1");
      run_div(16'd50, 16'd5, 3, "50/5_ignored_start");

      // Asynchronous reset in the middle of a division.
      @(negedge clk);
      bus.start    = 1'b1;
      bus.dividend = 16'd1000;
      bus.divisor  = 16'd3;
      @(posedge clk);
      #1;
      bus.start = 1'b0;
      repeat (20) @(posedge clk);
      #2;
      rst_n = 1'b0;
      #1;
      check("midreset busy", bus.busy, 0);
      check("midreset done", bus.done, 0);
      check("midreset quotient", bus.quotient, 0);
      check("midreset remainder", bus.remainder, 0);
      check("midreset dbz", bus.div_by_zero, 0);
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk);
      #1;
      check("postreset busy", bus.busy, 0);
      check("postreset done", bus.done, 0);
      $display("reset mid-division: outputs cleared");
      last_q = '0;
      last_r = '0;
      last_z = 1'b0;
      run_div(16'd10, 16'd4, 0, "10/4");

      // Random operands, with the quotient kept small to bound run time.
      for (int i = 0; i < 24; i++) begin
         ra = W'($urandom);
         if (i % 6 == 5) begin
            rb = '0;
         end else begin
            rb = W'($urandom_range(1, 65535));
            if (ra / rb > 200) rb = ra / 200 + 16'd1;
         end
         run_div(ra, rb, 0, $sformatf("rand%0d", i));
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
